// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port controller shared by instruction fetch and the load/store buffer.
// Optional build macro MEM_ROUND_ROBIN_EN enables alternating arbitration; otherwise LSB has fixed priority.
module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        lsb_valid,
  input  logic        lsb_wr,
  input  logic [2:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_value,
  output logic        lsb_ready,
  output logic [31:0] lsb_result,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    get_byte = w[7:0];
      2'd1:    get_byte = w[15:8];
      2'd2:    get_byte = w[23:16];
      default: get_byte = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                         input logic zext);
    case (n)
      3'd1:    return zext ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      3'd2:    return zext ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [2:0] len_bytes(input logic [1:0] l);
    case (l)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] seg);
    return seg == IO_SEL;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s;
  logic [2:0]  n_r, n_s;
  logic        zext_r, zext_s;
  logic [31:0] wdata_r, wdata_s;
  logic        owner_lsb_r, owner_lsb_s;
  logic        is_wr_r, is_wr_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [31:0] buf_r, buf_s;
  logic [31:0] mem_a_r, mem_a_s;
  logic [7:0]  mem_dout_r, mem_dout_s;
  logic        mem_wr_r, mem_wr_s;
  logic        if_ready_r, if_ready_s;
  logic [31:0] if_data_r, if_data_s;
  logic        lsb_ready_r, lsb_ready_s;
  logic [31:0] lsb_result_r, lsb_result_s;
  logic        pick_lsb_s, pick_if_s;
  logic [31:0] byte_addr_s;
  logic [1:0]  cap_idx_s;
`ifdef MEM_ROUND_ROBIN_EN
  logic        rr_if_first_r, rr_if_first_s;
`endif

  // Arbitration between the two requesters; only granted from IDLE without a flush
  always_comb begin
    pick_lsb_s = 1'b0;
    pick_if_s  = 1'b0;
    if (state_r == ST_IDLE && !rob_clear) begin
`ifdef MEM_ROUND_ROBIN_EN
      pick_lsb_s = lsb_valid && !(if_valid && rr_if_first_r);
`else
      pick_lsb_s = lsb_valid;
`endif
      pick_if_s  = if_valid && !pick_lsb_s;
    end else begin
      pick_lsb_s = 1'b0;
      pick_if_s  = 1'b0;
    end
  end

  // Next-state and next-output logic of the access FSM
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    n_s          = n_r;
    zext_s       = zext_r;
    wdata_s      = wdata_r;
    owner_lsb_s  = owner_lsb_r;
    is_wr_s      = is_wr_r;
    cnt_s        = cnt_r;
    buf_s        = buf_r;
    mem_a_s      = mem_a_r;
    mem_dout_s   = mem_dout_r;
    mem_wr_s     = 1'b0;
    if_ready_s   = 1'b0;
    if_data_s    = if_data_r;
    lsb_ready_s  = 1'b0;
    lsb_result_s = lsb_result_r;
    byte_addr_s  = addr_r + {29'd0, cnt_r};
    cap_idx_s    = cnt_r[1:0] - 2'd1;
`ifdef MEM_ROUND_ROBIN_EN
    rr_if_first_s = rr_if_first_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_lsb_s || pick_if_s) begin
          owner_lsb_s = pick_lsb_s;
          is_wr_s     = pick_lsb_s && lsb_wr;
          addr_s      = pick_lsb_s ? lsb_addr : if_addr;
          n_s         = pick_lsb_s ? len_bytes(lsb_len[1:0]) : 3'd4;
          zext_s      = lsb_len[2];
          wdata_s     = lsb_value;
          buf_s       = 32'd0;
          mem_a_s     = addr_s;
`ifdef MEM_ROUND_ROBIN_EN
          rr_if_first_s = pick_lsb_s;
`endif
          if (is_wr_s) begin
            state_s = ST_WRITE;
            if (is_io(lsb_addr[17:16]) && io_buffer_full) begin
              cnt_s    = 3'd0;
              mem_wr_s = 1'b0;
            end else begin
              cnt_s      = 3'd1;
              mem_wr_s   = 1'b1;
              mem_dout_s = lsb_value[7:0];
            end
          end else begin
            state_s = ST_READ;
            cnt_s   = 3'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        // cnt_r counts READ cycles; byte cnt_r-1 is on mem_din this cycle
        if (rob_clear) begin
          state_s = ST_IDLE;
          cnt_s   = 3'd0;
        end else begin
          if (cnt_r != 3'd0) begin
            buf_s = put_byte(buf_r, cap_idx_s, mem_din);
          end else begin
            buf_s = buf_r;
          end
          if (cnt_r == n_r) begin
            state_s = ST_DONE;
            if (owner_lsb_r) begin
              lsb_ready_s  = 1'b1;
              lsb_result_s = extend(buf_s, n_r, zext_r);
            end else begin
              if_ready_s = 1'b1;
              if_data_s  = buf_s;
            end
          end else begin
            cnt_s   = cnt_r + 3'd1;
            mem_a_s = byte_addr_s + 32'd1;
          end
        end
      end
      ST_WRITE: begin
        // cnt_r counts bytes already placed on the bus
        if (cnt_r == n_r) begin
          state_s     = ST_DONE;
          lsb_ready_s = 1'b1;
          mem_wr_s    = 1'b0;
        end else begin
          mem_a_s = byte_addr_s;
          if (is_io(byte_addr_s[17:16]) && io_buffer_full) begin
            mem_wr_s = 1'b0;
          end else begin
            mem_wr_s   = 1'b1;
            mem_dout_s = get_byte(wdata_r, cnt_r[1:0]);
            cnt_s      = cnt_r + 3'd1;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      addr_r       <= 32'd0;
      n_r          <= 3'd0;
      zext_r       <= 1'b0;
      wdata_r      <= 32'd0;
      owner_lsb_r  <= 1'b0;
      is_wr_r      <= 1'b0;
      cnt_r        <= 3'd0;
      buf_r        <= 32'd0;
      mem_a_r      <= 32'd0;
      mem_dout_r   <= 8'd0;
      mem_wr_r     <= 1'b0;
      if_ready_r   <= 1'b0;
      if_data_r    <= 32'd0;
      lsb_ready_r  <= 1'b0;
      lsb_result_r <= 32'd0;
`ifdef MEM_ROUND_ROBIN_EN
      rr_if_first_r <= 1'b1;
`endif
    end else if (rdy_in) begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      n_r          <= n_s;
      zext_r       <= zext_s;
      wdata_r      <= wdata_s;
      owner_lsb_r  <= owner_lsb_s;
      is_wr_r      <= is_wr_s;
      cnt_r        <= cnt_s;
      buf_r        <= buf_s;
      mem_a_r      <= mem_a_s;
      mem_dout_r   <= mem_dout_s;
      mem_wr_r     <= mem_wr_s;
      if_ready_r   <= if_ready_s;
      if_data_r    <= if_data_s;
      lsb_ready_r  <= lsb_ready_s;
      lsb_result_r <= lsb_result_s;
`ifdef MEM_ROUND_ROBIN_EN
      rr_if_first_r <= rr_if_first_s;
`endif
    end
  end

  // A flush seen in the DONE cycle of a read suppresses its ready pulse
  assign if_ready   = if_ready_r & rdy_in & ~rob_clear;
  assign lsb_ready  = lsb_ready_r & rdy_in & ~(rob_clear & ~is_wr_r);
  assign if_data    = if_data_r;
  assign lsb_result = lsb_result_r;
  assign mem_a      = mem_a_r;
  assign mem_dout   = mem_dout_r;
  assign mem_wr     = mem_wr_r & rdy_in;

endmodule
